// File: rtl/pixel_framebuffer.sv
// Double-buffered 3-bit-colour frame buffer feeding the VGA driver.
// Back-bank writes/clears from game logic; front/back swap is held until a frame boundary.
module pixel_framebuffer #(
  parameter int WIDTH  = 160,
  parameter int HEIGHT = 120,
  parameter int AW     = $clog2(WIDTH*HEIGHT)
) (
  input  logic       CLOCK_50,
  input  logic       reset_n,
  input  logic [9:0] x,
  input  logic [8:0] y,
  output logic [7:0] r,
  output logic [7:0] g,
  output logic [7:0] b,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [9:0] wr_x,
  input  logic [8:0] wr_y,
  input  logic [2:0] wr_color,
  input  logic       clear_req,
  input  logic [2:0] clear_color,
  input  logic       swap_req,
  output logic       swap_done,
  output logic       busy,
  output logic       front_sel
);

  localparam int NPIX = WIDTH * HEIGHT;
  localparam logic [AW-1:0] LAST_ADDR = AW'(NPIX - 1);

  typedef enum logic [1:0] {IDLE, CLEAR, SWAP_WAIT} state_t;
  state_t state, state_n;

  logic [2:0]    bank0 [NPIX];
  logic [2:0]    bank1 [NPIX];
  logic [AW-1:0] clr_addr;
  logic [2:0]    clr_color_q;
  logic [8:0]    y_last;
  logic [2:0]    rd_q;
  logic          rd_valid_q;

  logic          rd_in_range, wr_in_range, boundary;
  logic [AW-1:0] rd_addr, wr_addr, mem_addr;
  logic [2:0]    mem_data;
  logic          start_clear, clr_we, mem_we;

  always_comb begin
    rd_in_range = (32'(x) < WIDTH) && (32'(y) < HEIGHT);
    wr_in_range = (32'(wr_x) < WIDTH) && (32'(wr_y) < HEIGHT);
    // Addresses are only formed for in-range coordinates so the product never overflows AW.
    rd_addr     = rd_in_range ? AW'(32'(y) * WIDTH + 32'(x)) : '0;
    wr_addr     = wr_in_range ? AW'(32'(wr_y) * WIDTH + 32'(wr_x)) : '0;
    boundary    = (y_last != '0) && (y == '0);
  end

  always_comb begin
    state_n     = state;
    swap_done   = 1'b0;
    start_clear = 1'b0;
    clr_we      = 1'b0;
    case (state)
      IDLE: begin
        if (clear_req) begin
          state_n     = CLEAR;
          start_clear = 1'b1;
        end else if (swap_req) begin
          state_n = SWAP_WAIT;
        end
      end
      CLEAR: begin
        clr_we = 1'b1;
        if (clr_addr == LAST_ADDR) state_n = IDLE;
      end
      SWAP_WAIT: begin
        if (boundary) begin
          swap_done = 1'b1;
          state_n   = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != IDLE);
    wr_ready = (state == IDLE);
    mem_we   = clr_we || (wr_ready && wr_valid && wr_in_range);
    mem_addr = clr_we ? clr_addr : wr_addr;
    mem_data = clr_we ? clr_color_q : wr_color;
  end

  // Memory and read stage are unreset; the validity flag below masks rd_q after reset.
  always_ff @(posedge CLOCK_50) begin
    if (mem_we) begin
      if (front_sel) bank0[mem_addr] <= mem_data;
      else           bank1[mem_addr] <= mem_data;
    end
    rd_q <= front_sel ? bank1[rd_addr] : bank0[rd_addr];
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      clr_addr    <= '0;
      clr_color_q <= '0;
      y_last      <= '0;
      front_sel   <= 1'b0;
      rd_valid_q  <= 1'b0;
      r           <= '0;
      g           <= '0;
      b           <= '0;
    end else begin
      state      <= state_n;
      y_last     <= y;
      rd_valid_q <= rd_in_range;
      r          <= (rd_valid_q && rd_q[2]) ? '1 : '0;
      g          <= (rd_valid_q && rd_q[1]) ? '1 : '0;
      b          <= (rd_valid_q && rd_q[0]) ? '1 : '0;
      if (start_clear) begin
        clr_addr    <= '0;
        clr_color_q <= clear_color;
      end else if (clr_we) begin
        clr_addr <= (clr_addr == LAST_ADDR) ? '0 : clr_addr + AW'(1);
      end
      if (swap_done) front_sel <= ~front_sel;
    end
  end

endmodule

// File: tb/tb_pixel_framebuffer.sv
// Self-checking bench for pixel_framebuffer: pixel-array reference model checked
// every cycle, plus directed literal checks for clear, swap, range and reset behaviour.
module tb_pixel_framebuffer;
  localparam int W = 160;
  localparam int H = 120;
  localparam int N = W * H;

  logic       CLOCK_50 = 1'b0;
  logic       reset_n = 1'b0;
  logic [9:0] x = '0, wr_x = '0;
  logic [8:0] y = '0, wr_y = '0;
  logic [7:0] r, g, b;
  logic       wr_valid = 1'b0, wr_ready;
  logic [2:0] wr_color = '0, clear_color = '0;
  logic       clear_req = 1'b0, swap_req = 1'b0;
  logic       swap_done, busy, front_sel;

  int errors = 0;
  int checks = 0;

  pixel_framebuffer #(.WIDTH(W), .HEIGHT(H)) dut (
    .CLOCK_50(CLOCK_50), .reset_n(reset_n), .x(x), .y(y), .r(r), .g(g), .b(b),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_x(wr_x), .wr_y(wr_y), .wr_color(wr_color),
    .clear_req(clear_req), .clear_color(clear_color), .swap_req(swap_req),
    .swap_done(swap_done), .busy(busy), .front_sel(front_sel)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  // Reference model: two pixel arrays (-1 = never written), a clear countdown,
  // a pending-swap flag and a two-deep queue of expected read colours.
  int mem [2][N];
  int m_front = 0, m_clear_left = 0, m_clear_idx = 0, m_clear_c = 0;
  int m_prev_y = 0, m_rd1 = 0, m_rgb = 0;
  bit m_swap = 1'b0;
  bit m_busy, m_bnd;

  initial for (int i = 0; i < N; i++) begin mem[0][i] = -1; mem[1][i] = -1; end

  function automatic logic [23:0] expand(input int c);
    logic [2:0] cb;
    cb = 3'(c);
    return {cb[2] ? 8'hFF : 8'h00, cb[1] ? 8'hFF : 8'h00, cb[0] ? 8'hFF : 8'h00};
  endfunction

  always @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      m_front = 0; m_clear_left = 0; m_swap = 1'b0;
      m_prev_y = 0; m_rd1 = 0; m_rgb = 0;
    end else begin
      m_busy = (m_clear_left > 0) || m_swap;
      m_bnd  = (m_prev_y != 0) && (int'(y) == 0);
      m_rgb  = m_rd1;
      if (int'(x) < W && int'(y) < H) m_rd1 = mem[m_front][int'(y) * W + int'(x)];
      else m_rd1 = 0;
      if (!m_busy) begin
        if (wr_valid && int'(wr_x) < W && int'(wr_y) < H)
          mem[1 - m_front][int'(wr_y) * W + int'(wr_x)] = int'(wr_color);
        if (clear_req) begin
          m_clear_left = N; m_clear_idx = 0; m_clear_c = int'(clear_color);
        end else if (swap_req) begin
          m_swap = 1'b1;
        end
      end else if (m_clear_left > 0) begin
        mem[1 - m_front][m_clear_idx] = m_clear_c;
        m_clear_idx++;
        m_clear_left--;
      end else if (m_bnd) begin
        m_front = 1 - m_front;
        m_swap  = 1'b0;
      end
      m_prev_y = int'(y);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLOCK_50) begin
    bit eb;
    eb = (m_clear_left > 0) || m_swap;
    chk("busy", 32'(busy), 32'(eb));
    chk("wr_ready", 32'(wr_ready), 32'(!eb));
    chk("front_sel", 32'(front_sel), 32'(m_front));
    chk("swap_done", 32'(swap_done),
        32'(m_swap && m_clear_left == 0 && m_prev_y != 0 && y == 0));
    if (m_rgb >= 0) chk("rgb", 32'({r, g, b}), 32'(expand(m_rgb)));
  end

  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic rand_read();
    x = 10'($urandom_range(0, 255));
    y = 9'($urandom_range(0, 140));
  endtask

  task automatic do_clear(input logic [2:0] c);
    int cnt;
    clear_color = c;
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    cnt = 0;
    while (busy && cnt < 20000) begin
      cnt++;
      rand_read();
      wr_valid  = 1'($urandom_range(0, 1));
      wr_x      = 10'($urandom_range(0, 170));
      wr_y      = 9'($urandom_range(0, 125));
      wr_color  = 3'($urandom_range(0, 7));
      clear_req = ($urandom_range(0, 99) == 0);
      swap_req  = ($urandom_range(0, 99) == 0);
      step();
    end
    wr_valid = 1'b0; clear_req = 1'b0; swap_req = 1'b0;
    chk("clear_len", 32'(cnt), 32'(N));
  endtask

  task automatic do_swap(input logic exp_front);
    y = 9'd119;
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    chk("swap_busy", 32'(busy), 32'd1);
    repeat (3) step();
    chk("swap_early", 32'(swap_done), 32'd0);
    y = 9'd0;
    #1;
    chk("swap_done_at_boundary", 32'(swap_done), 32'd1);
    step();
    chk("swap_front", 32'(front_sel), 32'(exp_front));
    chk("swap_idle", 32'(busy), 32'd0);
  endtask

  task automatic write_px(input int xx, input int yy, input logic [2:0] c);
    wr_x = 10'(xx); wr_y = 9'(yy); wr_color = c; wr_valid = 1'b1;
    chk("write_ready", 32'(wr_ready), 32'd1);
    step();
    wr_valid = 1'b0;
  endtask

  task automatic read_px(input string name, input int xx, input int yy, input logic [23:0] exp);
    x = 10'(xx); y = 9'(yy);
    step();
    step();
    chk(name, 32'({r, g, b}), 32'(exp));
  endtask

  initial begin
    repeat (3) step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_front", 32'(front_sel), 32'd0);
    chk("rst_ready", 32'(wr_ready), 32'd1);
    chk("rst_rgb", 32'({r, g, b}), 32'd0);
    reset_n = 1'b1;
    step();

    repeat (200) begin rand_read(); step(); end

    do_clear(3'b100);
    do_swap(1'b1);
    read_px("red_5_7", 5, 7, 24'hFF0000);

    do_clear(3'b011);
    write_px(0, 0, 3'b010);
    write_px(159, 119, 3'b001);
    write_px(160, 0, 3'b100);
    do_swap(1'b0);
    read_px("green_0_0", 0, 0, 24'h00FF00);
    read_px("blue_159_119", 159, 119, 24'h0000FF);
    read_px("oor_write_dropped", 0, 1, 24'h00FFFF);
    read_px("oor_read_x200", 200, 5, 24'h000000);
    read_px("cleared_5_7", 5, 7, 24'h00FFFF);

    do_swap(1'b1);
    clear_color = 3'b110;
    clear_req = 1'b1;
    swap_req = 1'b1;
    step();
    clear_req = 1'b0;
    swap_req = 1'b0;
    repeat (4999) begin rand_read(); step(); end
    chk("midclear_busy", 32'(busy), 32'd1);
    chk("midclear_front", 32'(front_sel), 32'd1);
    @(posedge CLOCK_50);
    #3 reset_n = 1'b0;
    #1;
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_front", 32'(front_sel), 32'd0);
    chk("async_rst_ready", 32'(wr_ready), 32'd1);
    step();
    step();
    reset_n = 1'b1;
    step();
    do_swap(1'b1);
    read_px("after_rst_red", 10, 20, 24'hFF0000);

    repeat (4000) begin
      rand_read();
      if ($urandom_range(0, 3) == 0) y = 9'd0;
      wr_valid = 1'($urandom_range(0, 1));
      wr_x     = 10'($urandom_range(0, 170));
      wr_y     = 9'($urandom_range(0, 125));
      wr_color = 3'($urandom_range(0, 7));
      swap_req = ($urandom_range(0, 29) == 0);
      step();
    end
    wr_valid = 1'b0;
    swap_req = 1'b0;
    repeat (4) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pixel_framebuffer.md
# pixel_framebuffer

Double-buffered 3-bit-colour frame buffer that sits directly upstream of the VGA video driver. It answers the driver's per-pixel (x, y) requests with 8-bit r/g/b and accepts pixel writes from game logic into the back buffer. It also provides a hardware clear of the back buffer and a buffer swap synchronised to the frame boundary, so drawing never tears.

## Interface
- WIDTH, 160: logical pixels per line; must match the driver's WIDTH.
- HEIGHT, 120: logical lines per frame; must match the driver's HEIGHT.
- AW, $clog2(WIDTH*HEIGHT): address width of one buffer.
- CLOCK_50  in  1  sole clock; all logic on its rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- x  in  10  driver read column.
- y  in  9  driver read line.
- r, g, b  out  8 each  pixel colour to the driver.
- wr_valid  in  1  pixel write request.
- wr_ready  out  1  write accepted when high together with wr_valid.
- wr_x  in  10  write column.
- wr_y  in  9  write line.
- wr_color  in  3  {R,G,B} bits.
- clear_req  in  1  single-cycle pulse; fill the back buffer with clear_color.
- clear_color  in  3  fill colour, sampled in the cycle clear_req is accepted.
- swap_req  in  1  single-cycle pulse; exchange front and back at the next frame boundary.
- swap_done  out  1  one-cycle pulse in the cycle the swap takes effect.
- busy  out  1  high whenever state != IDLE.
- front_sel  out  1  which buffer (0/1) is displayed.

## Operation
- Storage: two banks of WIDTH*HEIGHT × 3 bits, addr = y*WIDTH + x. Memory contents are not reset.
- Read path: reads the front bank (front_sel).
  - Each output channel is 8'hFF if its bit is 1, else 8'h00.
  - If x >= WIDTH or y >= HEIGHT, output black (all channels 0).
- Write path: writes go to the back bank (~front_sel).
  - A write occurs when wr_valid && wr_ready.
  - An in-range write stores wr_color.
  - An out-of-range write is accepted and dropped.
- wr_ready = (state == IDLE).
- FSM states: IDLE, CLEAR, SWAP_WAIT.
  - IDLE → CLEAR on clear_req. Latch clear_color; set clr_addr = 0.
  - IDLE → SWAP_WAIT on swap_req, when clear_req is not also asserted.
  - CLEAR: write clear_color to the back bank at clr_addr, one address per cycle. After writing WIDTH*HEIGHT-1, go to IDLE.
  - SWAP_WAIT: on a frame boundary, toggle front_sel, pulse swap_done, and go to IDLE.
- Frame boundary: the cycle where registered y_last != 0 and the current y == 0. y_last resets to 0.
- Requests made outside IDLE are ignored; clear_req and swap_req are not queued.
- clear_req and swap_req together in IDLE: clear wins; the swap is dropped.
- wr_valid and clear_req together in IDLE: the write completes, then the clear overwrites it.

## Timing
- Reset values:
  - r, g, b = 0; swap_done = 0; busy = 0; front_sel = 0
  - state = IDLE; wr_ready = 1; clr_addr = 0; y_last = 0.
- Read latency: 2 CLOCK_50 cycles from x/y to r/g/b.
  - Cycle 1: synchronous RAM read (address computed combinationally).
  - Cycle 2: colour expansion register.
  - The driver's x/y change at most every 2 CLOCK_50 cycles, so r/g/b are stable before the next CLOCK_25 sample.
- The bank used by the read path switches starting with the read issued in the cycle after the swap_done pulse.
- A write, a clear step, and a read may all occur in the same cycle. They target different banks, so there is no conflict.
- Clear duration: exactly WIDTH*HEIGHT cycles (19200 at defaults).
  - busy rises the cycle after clear_req.
  - busy falls the cycle after the last address is written.
- Swap duration: from the cycle after swap_req until the boundary cycle; busy is high throughout.
- Reset asserted mid-clear or mid-swap: immediate return to IDLE. A partial clear is left as is; front_sel returns to 0.

## Test plan
- Reset, then sweep x/y across all reads → r/g/b = 0 or stale RAM only; busy=0, front_sel=0, wr_ready=1.
- clear_req with clear_color=3'b100 → busy high for 19200 cycles, wr_ready low meanwhile. Then swap and read (5,7) → r=8'hFF, g=8'h00, b=8'h00.
- Write (0,0)=3'b010 and (159,119)=3'b001, then swap_req → swap_done only after y goes 119→0. Reading (0,0) → g=8'hFF; reading (159,119) → b=8'hFF. Both appear 2 cycles after x/y.
- Out-of-range: write (160,0) is accepted with no RAM change. Read x=200 → r/g/b=0 regardless of contents.
- clear_req and swap_req in the same cycle → only the clear runs; front_sel unchanged; no swap_done.
- Deassert reset_n mid-clear (cycle 5000) → busy=0 and front_sel=0 asynchronously. A fresh swap_req after release completes normally.
